// File: rtl/execute_multicycle_ctrl.sv
// Sequencer for iterative execute-stage units (divider, clmul, ...).
// Starts the selected unit, stalls execute until it reports ready, parks the
// result across downstream holds, aborts on flush and on a watchdog expiry.
module execute_multicycle_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUNIT   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [NUNIT-1:0]      issue_unit,
    input  logic [4:0]            issue_waddr,
    input  logic                  hold,
    input  logic                  kill,
    output logic [NUNIT-1:0]      unit_enable,
    output logic [NUNIT-1:0]      unit_abort,
    input  logic [NUNIT-1:0]      unit_ready,
    input  logic [NUNIT*XLEN-1:0] unit_result,
    output logic                  stall,
    output logic                  wb_valid,
    output logic                  wb_wren,
    output logic [4:0]            wb_waddr,
    output logic [XLEN-1:0]       wb_wdata,
    output logic                  busy,
    output logic                  timeout
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
    localparam int unsigned CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CntLastInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CntLast  = CntLastInt[CW-1:0];

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [NUNIT-1:0]  sel_q, sel_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept;
    logic              sel_ready;
    logic              watchdog_hit;
    logic [XLEN-1:0]   sel_result;

    // Gating with reset keeps every output low while reset is held, even in IDLE.
    assign accept       = reset & issue_valid & $onehot(issue_unit) & ~kill & ~hold;
    assign sel_ready    = |(unit_ready & sel_q);
    assign watchdog_hit = (TIMEOUT != 0) && (cnt_q == CntLast) && !sel_ready;

    // Pick the result lane of the in-flight unit.
    always_comb begin
        sel_result = '0;
        for (int i = 0; i < int'(NUNIT); i++) begin
            if (sel_q[i]) begin
                sel_result = sel_result | unit_result[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        waddr_d     = waddr_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        unit_enable = '0;
        unit_abort  = '0;
        stall       = 1'b0;
        wb_valid    = 1'b0;
        wb_wdata    = '0;
        timeout     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unit_enable = issue_unit;
                    stall       = 1'b1;
                    sel_d       = issue_unit;
                    waddr_d     = issue_waddr;
                    cnt_d       = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (kill) begin
                    unit_abort = sel_q;
                    state_d    = StIdle;
                end else if (watchdog_hit) begin
                    timeout    = 1'b1;
                    unit_abort = sel_q;
                    state_d    = StIdle;
                end else if (sel_ready && !hold) begin
                    wb_valid = 1'b1;
                    wb_wdata = sel_result;
                    state_d  = StIdle;
                end else if (sel_ready) begin
                    result_d = sel_result;
                    state_d  = StDone;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (!hold) begin
                    wb_valid = 1'b1;
                    wb_wdata = result_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign wb_waddr = waddr_q;
    assign wb_wren  = wb_valid & (|waddr_q);
    assign busy     = (state_q != StIdle);

    // State register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            waddr_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            waddr_q  <= waddr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_execute_multicycle_ctrl.sv
// Directed bench for execute_multicycle_ctrl: per-cycle reference model plus
// hand-computed literal checks at key cycles.
module tb_execute_multicycle_ctrl;

    localparam int XL = 32;
    localparam int NU = 2;
    localparam int TO = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            issue_valid = 1'b0;
    logic [NU-1:0]   issue_unit = '0;
    logic [4:0]      issue_waddr = '0;
    logic            hold = 1'b0;
    logic            kill = 1'b0;
    logic [NU-1:0]   unit_enable;
    logic [NU-1:0]   unit_abort;
    logic [NU-1:0]   unit_ready = '0;
    logic [NU*XL-1:0] unit_result = '0;
    logic            stall;
    logic            wb_valid;
    logic            wb_wren;
    logic [4:0]      wb_waddr;
    logic [XL-1:0]   wb_wdata;
    logic            busy;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    execute_multicycle_ctrl #(.XLEN(XL), .NUNIT(NU), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_unit  (issue_unit),
        .issue_waddr (issue_waddr),
        .hold        (hold),
        .kill        (kill),
        .unit_enable (unit_enable),
        .unit_abort  (unit_abort),
        .unit_ready  (unit_ready),
        .unit_result (unit_result),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_wren     (wb_wren),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction is either running (age = cycles since
    // issue), parked with a finished result, or absent.
    bit       m_run, m_park, n_run, n_park;
    int       m_unit, n_unit, m_age, n_age;
    logic [4:0]  m_dest, n_dest;
    logic [31:0] m_data, n_data;

    always @(negedge clock) begin
        logic [NU-1:0] e_en, e_ab;
        logic e_stall, e_wbv, e_to, rdy;
        logic [31:0] e_wd;
        n_run = m_run; n_park = m_park; n_unit = m_unit; n_age = m_age;
        n_dest = m_dest; n_data = m_data;
        if (!reset) begin
            n_run = 0; n_park = 0; n_unit = 0; n_age = 0; n_dest = '0; n_data = '0;
        end else begin
            e_en = '0; e_ab = '0; e_stall = 0; e_wbv = 0; e_to = 0; e_wd = '0;
            if (!m_run && !m_park) begin
                if (issue_valid && $countones(issue_unit) == 1 && !kill && !hold) begin
                    e_en = issue_unit; e_stall = 1;
                    for (int i = 0; i < NU; i++) if (issue_unit[i]) n_unit = i;
                    n_run = 1; n_age = 1; n_dest = issue_waddr;
                end
            end else if (m_run) begin
                rdy = unit_ready[m_unit];
                if (kill) begin
                    e_ab = NU'(1) << m_unit; n_run = 0;
                end else if (TO != 0 && m_age == TO && !rdy) begin
                    e_to = 1; e_ab = NU'(1) << m_unit; n_run = 0;
                end else if (rdy && !hold) begin
                    e_wbv = 1; e_wd = unit_result[m_unit*XL +: XL]; n_run = 0;
                end else if (rdy) begin
                    n_data = unit_result[m_unit*XL +: XL]; n_run = 0; n_park = 1;
                end else begin
                    e_stall = 1; n_age = m_age + 1;
                end
            end else begin
                if (kill) n_park = 0;
                else if (!hold) begin e_wbv = 1; e_wd = m_data; n_park = 0; end
            end
            chk("enable", 64'(unit_enable), 64'(e_en));
            chk("abort", 64'(unit_abort), 64'(e_ab));
            chk("stall", 64'(stall), 64'(e_stall));
            chk("wb_valid", 64'(wb_valid), 64'(e_wbv));
            chk("wb_wren", 64'(wb_wren), 64'(e_wbv && m_dest != 0));
            chk("wb_waddr", 64'(wb_waddr), 64'(m_dest));
            chk("wb_wdata", 64'(wb_wdata), 64'(e_wd));
            chk("busy", 64'(busy), 64'(m_run || m_park));
            chk("timeout", 64'(timeout), 64'(e_to));
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_run <= 0; m_park <= 0; m_unit <= 0; m_age <= 0; m_dest <= '0; m_data <= '0;
        end else begin
            m_run <= n_run; m_park <= n_park; m_unit <= n_unit; m_age <= n_age;
            m_dest <= n_dest; m_data <= n_data;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [NU-1:0] u, input logic [4:0] wa);
        issue_valid = 1'b1; issue_unit = u; issue_waddr = wa;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_unit = '0; issue_waddr = '0;
        hold = 1'b0; kill = 1'b0; unit_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("reset_outs", {unit_enable, unit_abort, stall, wb_valid, wb_wren, busy, timeout}, 0);
        chk("reset_waddr", 64'(wb_waddr), 0);
        #10 reset = 1'b1;
        next_cycle();

        // Basic: unit 1, waddr 7, ready in cycle 3; ready[0] in cycle 1 is ignored
        issue(2'b10, 5'd7);
        @(negedge clock);
        chk("t1_c0_enable", 64'(unit_enable), 64'h2);
        chk("t1_c0_stall", 64'(stall), 1);
        next_cycle(); idle_inputs(); unit_ready = 2'b01;
        @(negedge clock);
        chk("t1_c1_enable", 64'(unit_enable), 0);
        chk("t1_c1_stall", 64'(stall), 1);
        next_cycle(); unit_ready = '0;
        @(negedge clock);
        chk("t1_c2_stall", 64'(stall), 1);
        next_cycle(); unit_ready = 2'b10; unit_result = {32'hDEADBEEF, 32'h11111111};
        @(negedge clock);
        chk("t1_c3_wbv", 64'(wb_valid), 1);
        chk("t1_c3_wren", 64'(wb_wren), 1);
        chk("t1_c3_wdata", 64'(wb_wdata), 64'hDEADBEEF);
        chk("t1_c3_stall", 64'(stall), 0);

        // Back-to-back: waddr 0 on unit 0, ready in cycle 1
        next_cycle(); idle_inputs(); issue(2'b01, 5'd0);
        @(negedge clock);
        chk("t5_accept", 64'(unit_enable), 64'h1);
        next_cycle(); idle_inputs(); unit_ready = 2'b01; unit_result = {32'h0, 32'h00C0FFEE};
        @(negedge clock);
        chk("t5_wbv", 64'(wb_valid), 1);
        chk("t5_wren", 64'(wb_wren), 0);
        chk("t5_wdata", 64'(wb_wdata), 64'hC0FFEE);
        next_cycle(); idle_inputs();

        // Hold across ready: result parked, written in cycle 6
        issue(2'b10, 5'd7);
        next_cycle(); idle_inputs();
        next_cycle();
        next_cycle(); hold = 1'b1; unit_ready = 2'b10; unit_result = {32'hDEADBEEF, 32'h0};
        @(negedge clock);
        chk("t2_c3_stall", 64'(stall), 0);
        chk("t2_c3_wbv", 64'(wb_valid), 0);
        next_cycle(); unit_ready = '0; unit_result = {32'h12345678, 32'h0};
        @(negedge clock);
        chk("t2_c4_busy", 64'(busy), 1);
        chk("t2_c4_stall", 64'(stall), 0);
        next_cycle();
        @(negedge clock);
        chk("t2_c5_wbv", 64'(wb_valid), 0);
        next_cycle(); hold = 1'b0;
        @(negedge clock);
        chk("t2_c6_wbv", 64'(wb_valid), 1);
        chk("t2_c6_wdata", 64'(wb_wdata), 64'hDEADBEEF);
        next_cycle(); idle_inputs();

        // Parked result with a new issue (ignored) then kill (discarded)
        issue(2'b01, 5'd3);
        next_cycle(); idle_inputs(); hold = 1'b1; unit_ready = 2'b01;
        next_cycle(); unit_ready = '0; issue(2'b10, 5'd4);
        @(negedge clock);
        chk("done_ignores_issue", 64'(unit_enable), 0);
        next_cycle(); idle_inputs(); kill = 1'b1;
        @(negedge clock);
        chk("done_kill_wbv", 64'(wb_valid), 0);
        next_cycle(); idle_inputs();
        @(negedge clock);
        chk("done_kill_busy", 64'(busy), 0);
        next_cycle();

        // Kill in cycle 2 with ready; later ready ignored
        issue(2'b01, 5'd5);
        next_cycle(); idle_inputs();
        next_cycle(); kill = 1'b1; unit_ready = 2'b01;
        @(negedge clock);
        chk("t3_abort", 64'(unit_abort), 64'h1);
        chk("t3_wbv", 64'(wb_valid), 0);
        chk("t3_stall", 64'(stall), 0);
        next_cycle(); kill = 1'b0;
        @(negedge clock);
        chk("t3_late_ready", 64'(wb_valid), 0);
        next_cycle(); idle_inputs();

        // Watchdog
        issue(2'b01, 5'd9);
        next_cycle(); idle_inputs();
        next_cycle(); next_cycle();
        @(negedge clock);
        chk("t4_c3_timeout", 64'(timeout), 0);
        next_cycle();
        @(negedge clock);
        chk("t4_c4_timeout", 64'(timeout), 1);
        chk("t4_c4_abort", 64'(unit_abort), 64'h1);
        chk("t4_c4_stall", 64'(stall), 0);
        next_cycle();
        @(negedge clock);
        chk("t4_c5_busy", 64'(busy), 0);
        next_cycle();

        // Non-one-hot select
        issue(2'b11, 5'd2);
        @(negedge clock);
        chk("t6_enable", 64'(unit_enable), 0);
        chk("t6_stall", 64'(stall), 0);
        next_cycle(); idle_inputs();
        @(negedge clock);
        chk("t6_busy", 64'(busy), 0);
        next_cycle();

        // Asynchronous reset during WAIT
        issue(2'b10, 5'd9);
        next_cycle(); issue(2'b01, 5'd6);
        #2 reset = 1'b0;
        #1;
        chk("rst_outs", {unit_enable, unit_abort, stall, wb_valid, wb_wren, busy, timeout}, 0);
        chk("rst_waddr", 64'(wb_waddr), 0);
        idle_inputs();
        @(negedge clock);
        #1 reset = 1'b1;
        next_cycle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
